pedestrian_signal: RTL

PEDESTRIAN_SIGNAL -- requirements
Module: pedestrian_signal

---
 rtl/pedestrian_signal.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pedestrian_signal.sv
// Pedestrian crossing signal slaved to the vehicle traffic-light controller.
// Grants WALK on red entry when requested, then flashes DON'T-WALK.
module pedestrian_signal #(
    parameter int WALK_TIME  = 8,
    parameter int FLASH_TIME = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] light,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       ped_wait,
    output logic [3:0] walk_count,
    output logic       fault
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_WALK  = 2'd1,
        ST_FLASH = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    localparam logic [3:0] RED       = 4'd1;
    localparam logic [3:0] WALK_LOAD  = 4'(WALK_TIME - 1);
    localparam logic [3:0] FLASH_LOAD = 4'(FLASH_TIME - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       req_q, req_d;
    logic [3:0] prev_light_q;

    logic       walk_q, walk_d;
    logic       dont_walk_q, dont_walk_d;
    logic [3:0] walk_count_q, walk_count_d;
    logic       fault_q, fault_d;

    logic       one_hot;
    logic       red_entry;

    assign one_hot   = (light == 4'd1) || (light == 4'd2) ||
                       (light == 4'd4) || (light == 4'd8);
    assign red_entry = (light == RED) && (prev_light_q != RED);

    // State, counter, request latch, previous light and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_STOP;
            cnt_q        <= 4'd0;
            req_q        <= 1'b0;
            prev_light_q <= RED;
            walk_q       <= 1'b0;
            dont_walk_q  <= 1'b1;
            walk_count_q <= 4'd0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            prev_light_q <= light;
            walk_q       <= walk_d;
            dont_walk_q  <= dont_walk_d;
            walk_count_q <= walk_count_d;
            fault_q      <= fault_d;
        end
    end

    // Next state: fault beats abort beats expiry beats request/red entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        if (!one_hot) begin
            state_d = ST_FAULT;
            cnt_d   = 4'd0;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (red_entry && (req_q || ped_btn)) begin
                        state_d = ST_WALK;
                        cnt_d   = WALK_LOAD;
                        req_d   = 1'b0;
                    end else if (ped_btn) begin
                        req_d = 1'b1;
                    end
                end
                ST_WALK: begin
                    if (light != RED) begin
                        state_d = ST_STOP;
                        cnt_d   = 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        state_d = ST_FLASH;
                        cnt_d   = FLASH_LOAD;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_FLASH: begin
                    if (light != RED || cnt_q == 4'd0) begin
                        state_d = ST_STOP;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_FAULT;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Lamp decode from the next state so the lamps are registered
    always_comb begin
        walk_d       = 1'b0;
        dont_walk_d  = 1'b1;
        walk_count_d = 4'd0;
        fault_d      = 1'b0;
        case (state_d)
            ST_WALK: begin
                walk_d       = 1'b1;
                dont_walk_d  = 1'b0;
                walk_count_d = cnt_d;
            end
            ST_FLASH: begin
                dont_walk_d  = cnt_d[0];
                walk_count_d = cnt_d;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                dont_walk_d = 1'b1;
            end
        endcase
    end

    assign walk       = walk_q;
    assign dont_walk  = dont_walk_q;
    assign ped_wait   = req_q;
    assign walk_count = walk_count_q;
    assign fault      = fault_q;

endmodule
